// File: rtl/timebase_ctrl_if.sv
// Bus bundle between the time-base controller and its neighbours: direction strobes and busy
// flag in, sample strobe and active time/div index out.
interface timebase_ctrl_if #(
    parameter int IDX_W = 3
);
    logic [1:0]       dir;
    logic             capture_busy;
    logic             sample_tick;
    logic [IDX_W-1:0] tb_index;
    logic             tb_update;
    logic             pending;

    modport master (
        output dir, capture_busy,
        input  sample_tick, tb_index, tb_update, pending
    );

    modport slave (
        input  dir, capture_busy,
        output sample_tick, tb_index, tb_update, pending
    );
endinterface

// File: rtl/timebase_ctrl.sv
// DSO time-base controller: steps a time/div index from direction strobes and divides clk50 into
// sample_tick. Optional macro TB_WRAP_EN makes the requested index wrap instead of saturating.
module timebase_ctrl #(
    parameter int NUM_STEPS = 8,
    parameter int INIT_IDX  = 0,
    parameter int BASE_DIV  = 4,
    parameter int DIV_W     = 16,
    parameter int IDX_W     = 3
) (
    input  logic           clk50,
    input  logic           rst_n,
    timebase_ctrl_if.slave bus
);
    typedef enum logic {RUN, PEND} state_t;

    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_STEPS - 1);
    localparam logic [IDX_W-1:0] RST_IDX = IDX_W'(INIT_IDX);
    localparam logic [DIV_W-1:0] BASE    = DIV_W'(BASE_DIV);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] req_next;
    logic [IDX_W-1:0] act_idx;
    logic [IDX_W-1:0] act_next;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic             term;
    logic             mismatch;
    logic             apply;
    logic             sample_tick;
    logic             tb_update;
    logic             pending;

    assign div      = BASE << act_idx;
    assign term     = (cnt == div - DIV_W'(1));
    assign mismatch = (req_idx != act_idx);

    // Direction strobes only move the requested index; the active one follows at a period boundary.
    always_comb begin
        req_next = req_idx;
        if (bus.dir == 2'b10) begin
`ifdef TB_WRAP_EN
            req_next = (req_idx == MAX_IDX) ? '0 : req_idx + IDX_W'(1);
`else
            if (req_idx != MAX_IDX) req_next = req_idx + IDX_W'(1);
`endif
        end else if (bus.dir == 2'b01) begin
`ifdef TB_WRAP_EN
            req_next = (req_idx == '0) ? MAX_IDX : req_idx - IDX_W'(1);
`else
            if (req_idx != '0) req_next = req_idx - IDX_W'(1);
`endif
        end
    end

    always_comb begin
        state_next = state;
        apply      = 1'b0;
        case (state)
            RUN: begin
                if (mismatch) state_next = PEND;
            end
            PEND: begin
                if (!mismatch) begin
                    state_next = RUN;
                end else if (term && !bus.capture_busy) begin
                    apply      = 1'b1;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    assign act_next = apply ? req_idx : act_idx;

    // The apply edge is also the terminal count, so the counter restart serves both cases.
    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            state       <= RUN;
            req_idx     <= RST_IDX;
            act_idx     <= RST_IDX;
            cnt         <= '0;
            sample_tick <= 1'b0;
            tb_update   <= 1'b0;
            pending     <= 1'b0;
        end else begin
            state       <= state_next;
            req_idx     <= req_next;
            act_idx     <= act_next;
            cnt         <= term ? '0 : cnt + DIV_W'(1);
            sample_tick <= term;
            tb_update   <= apply;
            pending     <= (req_next != act_next);
        end
    end

    assign bus.sample_tick = sample_tick;
    assign bus.tb_index    = act_idx;
    assign bus.tb_update   = tb_update;
    assign bus.pending     = pending;
endmodule

// File: tb/tb_timebase_ctrl.sv
// Bench for timebase_ctrl: fixed vector table, hand-built corner sequences and random traffic,
// all checked against an event-time reference model of the time base.
module tb_timebase_ctrl;
    localparam int NUM_STEPS = 8;
    localparam int INIT_IDX  = 0;
    localparam int BASE_DIV  = 4;
    localparam int DIV_W     = 16;
    localparam int IDX_W     = 3;

    logic clk50 = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk50 = ~clk50;

    timebase_ctrl_if #(.IDX_W(IDX_W)) bus ();

    timebase_ctrl #(
        .NUM_STEPS(NUM_STEPS),
        .INIT_IDX (INIT_IDX),
        .BASE_DIV (BASE_DIV),
        .DIV_W    (DIV_W),
        .IDX_W    (IDX_W)
    ) dut (
        .clk50(clk50),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    typedef struct {
        logic       r;
        logic [1:0] d;
        logic       b;
        logic       tick;
        int         idx;
        logic       upd;
        logic       pend;
    } vec_t;

    vec_t vecs[$];

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: absolute edge times of ticks, integer indices.
    int m_req;
    int m_act;
    int m_cycle;
    int m_next_tick;
    bit m_outstanding;
    bit m_tick;
    bit m_upd;
    bit m_pend;

    function automatic int step_idx(input int idx, input logic [1:0] d);
        int n;
        n = idx;
        if (d == 2'b10) n = idx + 1;
        else if (d == 2'b01) n = idx - 1;
`ifdef TB_WRAP_EN
        n = (n + NUM_STEPS) % NUM_STEPS;
`else
        if (n < 0) n = 0;
        if (n > NUM_STEPS - 1) n = NUM_STEPS - 1;
`endif
        return n;
    endfunction

    // A request must have been outstanding before an edge to be applied at that edge.
    function automatic void model_edge(input logic r, input logic [1:0] d, input logic b);
        bit term;
        bit apply;
        bit mism;
        if (!r) begin
            m_req         = INIT_IDX;
            m_act         = INIT_IDX;
            m_cycle       = 0;
            m_next_tick   = BASE_DIV;
            m_outstanding = 1'b0;
            m_tick        = 1'b0;
            m_upd         = 1'b0;
            m_pend        = 1'b0;
        end else begin
            m_cycle++;
            term  = (m_cycle == m_next_tick);
            mism  = (m_req != m_act);
            apply = m_outstanding && mism && term && !b;
            m_outstanding = mism && !apply;
            if (apply) m_act = m_req;
            m_req  = step_idx(m_req, d);
            m_tick = term;
            m_upd  = apply;
            if (term) m_next_tick = m_cycle + (BASE_DIV << m_act);
            m_pend = (m_req != m_act);
        end
    endfunction

    function automatic void add_vec(input logic r, input logic [1:0] d, input logic b,
                                    input logic tick, input int idx, input logic upd,
                                    input logic pend);
        vec_t v;
        v.r = r; v.d = d; v.b = b; v.tick = tick; v.idx = idx; v.upd = upd; v.pend = pend;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name);
        vectors++;
        if (bus.sample_tick !== m_tick || bus.tb_index !== IDX_W'(m_act) ||
            bus.tb_update !== m_upd || bus.pending !== m_pend) begin
            miscompares++;
            $display("[TB] FAIL %s cycle %0d: got tick=%b idx=%0d upd=%b pend=%b, expected tick=%b idx=%0d upd=%b pend=%b",
                     name, m_cycle, bus.sample_tick, bus.tb_index, bus.tb_update, bus.pending,
                     m_tick, m_act, m_upd, m_pend);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic reportTimeout(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: timed out waiting, got no event, expected one", name);
    endtask

    task automatic applyStimulus(input logic r, input logic [1:0] d, input logic b);
        rst_n            = r;
        bus.dir          = d;
        bus.capture_busy = b;
        @(posedge clk50);
        #1;
        model_edge(r, d, b);
        checkOutput("model");
    endtask

    task automatic waitForIndex(input int target, input logic b, input int bound,
                                input string name);
        int k;
        k = 0;
        while (int'(bus.tb_index) != target && k < bound) begin
            applyStimulus(1'b1, 2'b00, b);
            k++;
        end
        if (int'(bus.tb_index) != target) reportTimeout(name);
    endtask

    task automatic waitForUpdate(input logic b, input int bound, input string name);
        int k;
        k = 0;
        do begin
            applyStimulus(1'b1, 2'b00, b);
            k++;
        end while (bus.tb_update !== 1'b1 && k < bound);
        if (bus.tb_update !== 1'b1) reportTimeout(name);
    endtask

    task automatic measurePeriod(input logic b, input int bound, input string name,
                                 output int p);
        int k;
        p = 0;
        k = 0;
        do begin
            applyStimulus(1'b1, 2'b00, b);
            k++;
        end while (bus.sample_tick !== 1'b1 && k < bound);
        if (bus.sample_tick !== 1'b1) begin
            reportTimeout(name);
            return;
        end
        do begin
            applyStimulus(1'b1, 2'b00, b);
            p++;
        end while (bus.sample_tick !== 1'b1 && p < bound);
    endtask

    task automatic countUpdates(input int n, input logic b, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 2'b00, b);
            if (bus.tb_update === 1'b1) c++;
        end
    endtask

    initial begin
        int p;
        int c;
        logic [1:0] rd;
        logic       rb;
        logic       rr;

        bus.dir          = 2'b00;
        bus.capture_busy = 1'b0;
        rst_n            = 1'b0;

        // Reset, first ticks at period 4, one slower step applied at the next terminal count.
        add_vec(1'b0, 2'b00, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        add_vec(1'b0, 2'b00, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 3; j++) add_vec(1'b1, 2'b00, 1'b0, 1'b0, 0, 1'b0, 1'b0);
            add_vec(1'b1, 2'b00, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        end
        add_vec(1'b1, 2'b10, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        add_vec(1'b1, 2'b00, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        add_vec(1'b1, 2'b00, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        add_vec(1'b1, 2'b00, 1'b0, 1'b1, 1, 1'b1, 1'b0);
        for (int j = 0; j < 7; j++) add_vec(1'b1, 2'b00, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        add_vec(1'b1, 2'b00, 1'b0, 1'b1, 1, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].r, vecs[i].d, vecs[i].b);
            vectors++;
            if (bus.sample_tick !== vecs[i].tick || int'(bus.tb_index) != vecs[i].idx ||
                bus.tb_update !== vecs[i].upd || bus.pending !== vecs[i].pend) begin
                miscompares++;
                $display("[TB] FAIL table row %0d: got tick=%b idx=%0d upd=%b pend=%b, expected tick=%b idx=%0d upd=%b pend=%b",
                         i, bus.sample_tick, bus.tb_index, bus.tb_update, bus.pending,
                         vecs[i].tick, vecs[i].idx, vecs[i].upd, vecs[i].pend);
            end
        end

        // Busy holds off a faster step from index 2 until it drops.
        applyStimulus(1'b0, 2'b00, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0);
        waitForIndex(2, 1'b0, 200, "busy_setup_idx");
        applyStimulus(1'b1, 2'b01, 1'b1);
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 2'b00, 1'b1);
        checkValue("busy_hold_pending", int'(bus.pending), 1);
        checkValue("busy_hold_idx", int'(bus.tb_index), 2);
        measurePeriod(1'b1, 200, "busy_period_wait", p);
        checkValue("busy_hold_period", p, 16);
        waitForUpdate(1'b0, 100, "busy_release_update");
        checkValue("busy_release_idx", int'(bus.tb_index), 1);
        measurePeriod(1'b0, 200, "busy_release_period_wait", p);
        checkValue("busy_release_period", p, 8);

        // Three slower strobes inside one sample period give one update.
        applyStimulus(1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b00, 1'b0);
        checkValue("burst_first_tick", int'(bus.sample_tick), 1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b10, 1'b0);
        countUpdates(60, 1'b0, c);
        checkValue("burst_update_count", c, 1);
        checkValue("burst_idx", int'(bus.tb_index), 3);
        measurePeriod(1'b0, 200, "burst_period_wait", p);
        checkValue("burst_period", p, 32);

        // Stepping past the top index.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b10, 1'b0);
        waitForIndex(7, 1'b0, 2000, "top_setup_idx");
        applyStimulus(1'b1, 2'b10, 1'b0);
`ifdef TB_WRAP_EN
        checkValue("top_step_pending", int'(bus.pending), 1);
        countUpdates(600, 1'b0, c);
        checkValue("top_step_updates", c, 1);
        checkValue("top_step_idx", int'(bus.tb_index), 0);
        measurePeriod(1'b0, 200, "top_step_period_wait", p);
        checkValue("top_step_period", p, 4);
`else
        checkValue("top_step_pending", int'(bus.pending), 0);
        countUpdates(600, 1'b0, c);
        checkValue("top_step_updates", c, 0);
        checkValue("top_step_idx", int'(bus.tb_index), 7);
`endif

        // Reset while a request is outstanding drops it.
        applyStimulus(1'b0, 2'b00, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0);
        checkValue("rst_pend_before", int'(bus.pending), 1);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkValue("rst_pend_after", int'(bus.pending), 0);
        checkValue("rst_pend_idx", int'(bus.tb_index), 0);
        checkValue("rst_pend_update", int'(bus.tb_update), 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b00, 1'b0);
        checkValue("rst_restart_no_early_tick", int'(bus.sample_tick), 0);
        applyStimulus(1'b1, 2'b00, 1'b0);
        checkValue("rst_restart_first_tick", int'(bus.sample_tick), 1);

        // Random strobes, busy bursts and rare resets against the model.
        rb = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 9))
                0:       rd = 2'b10;
                1:       rd = 2'b01;
                2:       rd = 2'b11;
                default: rd = 2'b00;
            endcase
            if ($urandom_range(0, 15) == 0) rb = ~rb;
            rr = ($urandom_range(0, 599) != 0);
            applyStimulus(rr, rd, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
